load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator for the single-port word memory (the ReadWriteMemory interface: addr, rd_en, wr_en, write_data, read_data). It takes RV32I load/store requests from the core (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready handshake and turns them into word-wide memory cycles. It performs byte-lane extraction with sign or zero extension, and does read-modify-write for sub-word stores. It sits between the core's execute stage and the data memory.

Parameters:
DATA_DEPTH, 16, number of 32-bit words in the attached memory
MEM_AW, $clog2(DATA_DEPTH), memory word-address width (derived; not overridden)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (size/sign)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal funct3 or out-of-range address
mem_addr  out  MEM_AW  word index, req_addr[MEM_AW+1:2]
mem_rd_en  out  1  memory read strobe
mem_wr_en  out  1  memory write strobe
mem_write_data  out  32  word written
mem_read_data  in  32  valid the cycle after mem_rd_en is sampled high

Behaviour:
- States: IDLE, RD, WAIT, WR, RESP. req_ready = (state==IDLE).
- Acceptance: on a clock edge with req_valid && req_ready, latch we/funct3/addr/wdata. Inputs are ignored outside IDLE.
- Error check at accept:
  - half-word with addr[0]!=0 -> error
  - word with addr[1:0]!=0 -> error
  - load funct3 in {3,6,7} -> error
  - store funct3 >2 -> error
  - addr[31:2] >= DATA_DEPTH -> error
  - On error: IDLE->RESP with rsp_err=1, rsp_rdata=0, no memory strobe.
- Load: IDLE->RD (mem_rd_en=1) ->WAIT (capture mem_read_data) ->RESP. rsp_valid is high in the 3rd cycle after the accept edge.
- Lane extraction:
  - byte = word[8*addr[1:0]+:8]; half = word[16*addr[1]+:16]
  - LB/LH sign-extend from the top bit; LBU/LHU zero-extend; LW passes the word through.
- SW: IDLE->WR (mem_wr_en=1, mem_write_data=wdata) ->RESP. Latency 2 cycles.
- SB/SH: IDLE->RD->WAIT (merge wdata[7:0]/[15:0] into the captured word at the lane) ->WR (merged word) ->RESP. Latency 4 cycles. Other lanes are preserved bit-exact.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure. The minimum accept-to-accept spacing is latency+1.
- mem_rd_en and mem_wr_en are never high in the same cycle. mem_addr is held stable from RD through WR.
- Reset:
  - State goes to IDLE; rsp_valid, rsp_err, rsp_rdata, mem_rd_en, mem_wr_en, mem_addr and mem_write_data are all 0.
  - Both mem strobes are forced 0 in any cycle where reset is high, including mid-RMW. An interrupted store leaves memory unchanged and produces no response.
  - req_ready=1 the first cycle after reset deasserts.

Decomposition:
- Shared package lsu_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5), state encoding localparams, and an access-size decode function.
- One natural sub-module, lsu_lane_unit (combinational):
  - extract+extend(word, off, funct3)
  - merge(word, wdata, off, funct3)
- The FSM and registers stay in load_store_unit.

Test Plan:
(Bench instantiates ReadWriteMemory with DATA_DEPTH=16 as the memory.)
1. SW addr 0x08, data 0xDEADBEEF -> single mem_wr_en pulse, mem_addr=2, mem_write_data=0xDEADBEEF, rsp_valid 2 cycles after accept with err=0. Then LW 0x08 -> rsp_rdata=0xDEADBEEF, 3 cycles after accept.
2. Loads of that word:
   - LB 0x09 -> 0xFFFFFFBE; LBU 0x09 -> 0x000000BE
   - LH 0x0A -> 0xFFFFDEAD; LHU 0x0A -> 0x0000DEAD
   - LB 0x0B -> 0xFFFFFFDE
3. SB 0x0B, wdata 0xFFFFFF12 -> one rd pulse, then one wr pulse with 0x12ADBEEF; LW 0x08 -> 0x12ADBEEF. Then SH 0x08, wdata 0x00005555 -> LW 0x08 -> 0x12AD5555.
4. Error cases, each giving rsp_err=1, rsp_rdata=0 and zero mem strobes, 1 cycle after accept:
   - LW 0x06 (misaligned)
   - LH 0x05 (misaligned)
   - SW 0x40 (word index 16, out of range)
   - load funct3=3
   - store funct3=4
5. SH 0x08 with reset asserted in the WR cycle -> no mem_wr_en, word stays 0x12AD5555, no rsp_valid. req_ready=1 the cycle after reset drops.
6. req_valid held high for 8 mixed requests -> req_ready high only in IDLE, exactly 8 rsp_valid pulses in request order, and mem_rd_en and mem_wr_en never both high.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding and the access-size decode used by both the FSM and the lane unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_RD   = S_RD,
        ST_WAIT = S_WAIT,
        ST_WR   = S_WR,
        ST_RESP = S_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_t;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic size_t access_size(input logic we, input logic [2:0] f3);
        size_t sz;
        case (f3)
            F3_B:    sz = SZ_BYTE;
            F3_H:    sz = SZ_HALF;
            F3_W:    sz = SZ_WORD;
            F3_BU:   sz = we ? SZ_BAD : SZ_BYTE;
            F3_HU:   sz = we ? SZ_BAD : SZ_HALF;
            default: sz = SZ_BAD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational byte-lane logic for the load/store unit.
// Ports:
//   word        - word read from memory
//   wdata       - right-aligned store data
//   off         - byte offset within the word (addr[1:0])
//   funct3      - RV32I size/sign code
//   load_data   - selected lane, sign or zero extended (word passes through)
//   merged_word - word with the store lane replaced, other lanes untouched
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    size_t       sz;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        sz          = access_size(1'b0, funct3);
        byte_v      = word[{off, 3'b000} +: 8];
        half_v      = word[{off[1], 4'b0000} +: 16];
        load_data   = word;
        merged_word = wdata;
        case (sz)
            SZ_BYTE: begin
                load_data = funct3[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
                merged_word = word;
                merged_word[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = funct3[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
                merged_word = word;
                merged_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data   = word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a single-port word memory.
// Accepts LB/LH/LW/LBU/LHU/SB/SH/SW over valid/ready, issues word-wide memory
// cycles, extracts/extends load lanes and does read-modify-write for SB/SH.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req_*                      - request from core (valid/ready handshake)
//   rsp_valid/rsp_rdata/rsp_err - one-cycle response pulse
//   mem_*                      - word memory interface (read data one cycle late)
//
// state   | meaning
// IDLE    | ready for a request
// RD      | memory read strobe issued
// WAIT    | read data returning; load extracts, RMW merges
// WR      | memory write strobe issued
// RESP    | rsp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int DATA_DEPTH = 16,
    localparam int MEM_AW     = $clog2(DATA_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        rd_en_q;
    logic        wr_en_q;

    size_t       req_sz;
    logic        misaligned;
    logic        out_of_range;
    logic        acc_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    always_comb begin
        req_sz       = access_size(req_we, req_funct3);
        misaligned   = ((req_sz == SZ_HALF) && req_addr[0]) ||
                       ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
        out_of_range = req_addr[31:2] >= 30'(DATA_DEPTH);
        acc_err      = (req_sz == SZ_BAD) || misaligned || out_of_range;
    end

    lsu_lane_unit u_lane (
        .word        (mem_read_data),
        .wdata       (wdata_q),
        .off         (off_q),
        .funct3      (funct3_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign req_ready = (state == ST_IDLE);

    // Strobes are gated by reset so a store interrupted in WR never writes.
    assign mem_rd_en = rd_en_q & ~reset;
    assign mem_wr_en = wr_en_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            we_q           <= 1'b0;
            funct3_q       <= 3'd0;
            off_q          <= 2'd0;
            wdata_q        <= 32'h0;
            rd_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= 32'h0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        wdata_q  <= req_wdata;
                        mem_addr <= req_addr[MEM_AW+1:2];
                        if (acc_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            state     <= ST_RESP;
                        end else if (req_we && (req_sz == SZ_WORD)) begin
                            mem_write_data <= req_wdata;
                            wr_en_q        <= 1'b1;
                            state          <= ST_WR;
                        end else begin
                            rd_en_q <= 1'b1;
                            state   <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    rd_en_q <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (we_q) begin
                        mem_write_data <= merged_word;
                        wr_en_q        <= 1'b1;
                        state          <= ST_WR;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    wr_en_q   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data = 32'h0;

    load_store_unit #(.DATA_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Word memory model: read data registered one cycle after rd_en is sampled.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_wr_data = 32'h0;
    int          last_wr_addr = -1;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_write_data;
            wr_cnt        <= wr_cnt + 1;
            last_wr_data  <= mem_write_data;
            last_wr_addr  <= int'(mem_addr);
        end
        if (mem_rd_en) begin
            mem_read_data <= mem[mem_addr];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   rsp_cnt = 0;
    int   ready_viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (req_ready && (rsp_valid || mem_rd_en || mem_wr_en)) ready_viol++;
        if (rsp_valid) begin
            rsp_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input bit expect_rsp, input bit hold);
        int budget;
        exp_t e;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (expect_rsp) begin
            e.rdata = er;
            e.err   = ee;
            e.lat   = lat;
            e.acc   = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while ((q.size() != 0 || !req_ready) && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0 || !req_ready) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    int rd0, wr0, rsp0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {30'h0, rsp_valid, rsp_err}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_strobes", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_wdata", mem_write_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // 1: SW then LW
        rd0 = rd_cnt; wr0 = wr_cnt;
        send(1, 3'd2, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2, 1, 0);
        wait_done();
        chk("sw_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        chk("sw_rd_pulses", 32'(rd_cnt - rd0), 32'd0);
        chk("sw_addr", 32'(last_wr_addr), 32'd2);
        chk("sw_data", last_wr_data, 32'hDEADBEEF);
        send(0, 3'd2, 32'h08, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0);
        wait_done();

        // 2: lane extraction
        send(0, 3'd0, 32'h09, 32'h0, 32'hFFFFFFBE, 0, 3, 1, 0);
        send(0, 3'd4, 32'h09, 32'h0, 32'h000000BE, 0, 3, 1, 0);
        send(0, 3'd1, 32'h0A, 32'h0, 32'hFFFFDEAD, 0, 3, 1, 0);
        send(0, 3'd5, 32'h0A, 32'h0, 32'h0000DEAD, 0, 3, 1, 0);
        send(0, 3'd0, 32'h0B, 32'h0, 32'hFFFFFFDE, 0, 3, 1, 0);
        wait_done();

        // 3: sub-word stores
        rd0 = rd_cnt; wr0 = wr_cnt;
        send(1, 3'd0, 32'h0B, 32'hFFFFFF12, 32'h0, 0, 4, 1, 0);
        wait_done();
        chk("sb_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        chk("sb_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        chk("sb_merged", last_wr_data, 32'h12ADBEEF);
        send(0, 3'd2, 32'h08, 32'h0, 32'h12ADBEEF, 0, 3, 1, 0);
        send(1, 3'd1, 32'h08, 32'h00005555, 32'h0, 0, 4, 1, 0);
        send(0, 3'd2, 32'h08, 32'h0, 32'h12AD5555, 0, 3, 1, 0);
        wait_done();

        // 4: error cases
        rd0 = rd_cnt; wr0 = wr_cnt;
        send(0, 3'd2, 32'h06, 32'h0, 32'h0, 1, 1, 1, 0);
        send(0, 3'd1, 32'h05, 32'h0, 32'h0, 1, 1, 1, 0);
        send(1, 3'd2, 32'h40, 32'h11111111, 32'h0, 1, 1, 1, 0);
        send(0, 3'd3, 32'h00, 32'h0, 32'h0, 1, 1, 1, 0);
        send(1, 3'd4, 32'h00, 32'h22222222, 32'h0, 1, 1, 1, 0);
        wait_done();
        chk("err_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

        // 5: reset during the WR cycle of an SH
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        send(1, 3'd1, 32'h08, 32'h0000AAAA, 32'h0, 0, 4, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("sh_in_wr", {31'h0, mem_wr_en}, 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_gates_wr", {31'h0, mem_wr_en}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", {31'h0, req_ready}, 32'h1);
        chk("interrupted_wr_pulses", 32'(wr_cnt - wr0), 32'd0);
        chk("interrupted_mem", mem[2], 32'h12AD5555);
        chk("interrupted_rsp", 32'(rsp_cnt - rsp0), 32'd0);

        // 6: back-to-back with req_valid held high
        rsp0 = rsp_cnt;
        send(1, 3'd2, 32'h00, 32'h11223344, 32'h0,        0, 2, 1, 1);
        send(0, 3'd2, 32'h00, 32'h0,        32'h11223344, 0, 3, 1, 1);
        send(0, 3'd0, 32'h03, 32'h0,        32'h00000011, 0, 3, 1, 1);
        send(1, 3'd0, 32'h01, 32'h000000AB, 32'h0,        0, 4, 1, 1);
        send(0, 3'd1, 32'h00, 32'h0,        32'hFFFFAB44, 0, 3, 1, 1);
        send(0, 3'd5, 32'h02, 32'h0,        32'h00001122, 0, 3, 1, 1);
        send(0, 3'd2, 32'h01, 32'h0,        32'h0,        1, 1, 1, 1);
        send(0, 3'd4, 32'h01, 32'h0,        32'h000000AB, 0, 3, 1, 0);
        wait_done();
        chk("burst_rsp_count", 32'(rsp_cnt - rsp0), 32'd8);
        chk("burst_mem0", mem[0], 32'h1122AB44);

        chk("ready_exclusive", 32'(ready_viol), 32'd0);
        chk("strobes_exclusive", 32'(both_cnt), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
